// File: rtl/jtframe_bank_arb.sv
// Round-robin read arbiter sharing one SDRAM bank among four ROM slots, each with a one-word hit cache.
// Optional macro JTFRAME_ARB_PRIO0_EN: slot 0 wins every grant, and slots 1-3 rotate among themselves.
module jtframe_bank_arb #(
   parameter int AW = 22,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4*AW-1:0] slot_addr,
   input  logic [3:0]      slot_cs,
   output logic [3:0]      slot_ok,
   output logic [4*DW-1:0] slot_dout,
   output logic            sdram_req,
   output logic [AW-1:0]   sdram_addr,
   input  logic            sdram_ack,
   input  logic            data_rdy,
   input  logic [DW-1:0]   data_read
);

   // Handshake: sdram_req and sdram_addr stay stable from the IDLE grant until the
   // first sdram_ack seen in REQ. data_read is accepted only on a data_rdy cycle in WAIT.
   typedef enum logic [1:0] { IDLE, REQ, WAIT } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] caddr [4];
   logic [3:0]    valid;
   logic [3:0]    pending;
   logic [1:0]    ptr, gnt, pick;
   logic          pick_vld;

   always_comb begin
      slot_ok = '0;
      for (int n = 0; n < 4; n++)
         slot_ok[n] = slot_cs[n] & valid[n] & (caddr[n] == slot_addr[n*AW +: AW]);
      pending = slot_cs & ~slot_ok;
   end

   // The first pending slot after ptr wins, so the last slot granted is checked last.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!pick_vld && pending[ptr + 2'(i)]) begin
            pick_vld = 1'b1;
            pick     = ptr + 2'(i);
         end
      end
`ifdef JTFRAME_ARB_PRIO0_EN
      if (pending[0]) begin
         pick_vld = 1'b1;
         pick     = 2'd0;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_vld)  state_nxt = REQ;
         REQ:     if (sdram_ack) state_nxt = WAIT;
         WAIT:    if (data_rdy)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         slot_dout  <= '0;
         valid      <= '0;
         ptr        <= 2'd3;
         gnt        <= 2'd0;
         for (int n = 0; n < 4; n++) caddr[n] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (pick_vld) begin
               gnt        <= pick;
               sdram_addr <= slot_addr[int'(pick)*AW +: AW];
               sdram_req  <= 1'b1;
`ifdef JTFRAME_ARB_PRIO0_EN
               if (pick != 2'd0) ptr <= pick;
`else
               ptr <= pick;
`endif
            end
            REQ: if (sdram_ack) sdram_req <= 1'b0;
            // The latched address is cached even if the slot has moved on, so a stale fill never reports ok.
            WAIT: if (data_rdy) begin
               slot_dout[int'(gnt)*DW +: DW] <= data_read;
               caddr[gnt]                    <= sdram_addr;
               valid[gnt]                    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Self-checking bench for jtframe_bank_arb: scenario tasks plus randomized traffic against a slot-cache model.
module tb_jtframe_bank_arb;
   localparam int AW = 22;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   a [4];
   logic [4*AW-1:0] slot_addr;
   logic [3:0]      slot_cs;
   logic [3:0]      slot_ok;
   logic [4*DW-1:0] slot_dout;
   logic            sdram_req;
   logic [AW-1:0]   sdram_addr;
   logic            sdram_ack;
   logic            data_rdy;
   logic [DW-1:0]   data_read;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: what each slot holds, plus the rotation pointer
   logic [AW-1:0] m_caddr [4];
   bit            m_valid [4];
   logic [DW-1:0] m_dout  [4];
   int            m_ptr;

   assign slot_addr = {a[3], a[2], a[1], a[0]};

   jtframe_bank_arb #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .slot_addr(slot_addr), .slot_cs(slot_cs),
      .slot_ok(slot_ok), .slot_dout(slot_dout), .sdram_req(sdram_req),
      .sdram_addr(sdram_addr), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
      .data_read(data_read)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] m_ok();
      logic [3:0] r;
      for (int n = 0; n < 4; n++)
         r[n] = slot_cs[n] && m_valid[n] && (m_caddr[n] == a[n]);
      return r;
   endfunction

   function automatic int m_pick();
      logic [3:0] pend;
      pend = slot_cs & ~m_ok();
`ifdef JTFRAME_ARB_PRIO0_EN
      if (pend[0]) return 0;
`endif
      for (int i = 1; i <= 4; i++)
         if (pend[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
      return -1;
   endfunction

   function automatic void m_grant(int s);
`ifdef JTFRAME_ARB_PRIO0_EN
      if (s != 0) m_ptr = s;
`else
      m_ptr = s;
`endif
   endfunction

   function automatic void m_fill(int s, logic [AW-1:0] ad, logic [DW-1:0] d);
      m_caddr[s] = ad;
      m_valid[s] = 1'b1;
      m_dout[s]  = d;
   endfunction

   function automatic logic [4*DW-1:0] m_dvec();
      return {m_dout[3], m_dout[2], m_dout[1], m_dout[0]};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 4; n++) begin
         m_valid[n] = 1'b0; m_caddr[n] = '0; m_dout[n] = '0;
      end
      m_ptr = 3;
   endtask

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (sdram_req === 1'b1) got = 1'b1;
      end
   endtask

   // Plays the SDRAM controller for one read; returns at the negedge after the data_rdy edge
   task automatic sdram_serve(input int ack_dly, input int rdy_dly, input bit noise,
                              input logic [DW-1:0] d, output bit got,
                              output logic [AW-1:0] ad, output bit stable, output bit dropped);
      wait_req(got);
      stable = 1'b1; dropped = 1'b0; ad = sdram_addr;
      if (!got) return;
      repeat (ack_dly) begin
         @(negedge clk);
         if (sdram_req !== 1'b1 || sdram_addr !== ad) stable = 1'b0;
      end
      sdram_ack = 1'b1;
      if (noise) begin data_rdy = 1'b1; data_read = ~d; end
      @(negedge clk);
      sdram_ack = 1'b0; data_rdy = 1'b0;
      dropped = (sdram_req === 1'b0);
      repeat (rdy_dly) begin
         sdram_ack = noise;
         @(negedge clk);
         sdram_ack = 1'b0;
      end
      data_rdy = 1'b1; data_read = d;
      @(negedge clk);
      data_rdy = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", sdram_req); end
      n_vec++; if (sdram_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
      n_vec++; if (slot_ok !== 4'b0) begin n_err++; $display("FAIL reset_ok: got %b want 0000", slot_ok); end
      n_vec++; if (slot_dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", slot_dout); end
   endtask

   task automatic test_single_miss();
      bit got, st, dr; logic [AW-1:0] ad;
      a[0] = 22'h1234; slot_cs = 4'b0001;
      #1;
      n_vec++; if (sdram_req !== 1'b0) begin n_err++; $display("FAIL miss_req_early: got %b want 0", sdram_req); end
      @(negedge clk);
      n_vec++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h1234) begin
         n_err++; $display("FAIL miss_req_latency: got req=%b addr=%h want 1/1234", sdram_req, sdram_addr); end
      sdram_serve(1, 2, 1'b0, 16'hBEEF, got, ad, st, dr);
      m_grant(0); m_fill(0, 22'h1234, 16'hBEEF);
      n_vec++; if (!got || !st || !dr) begin
         n_err++; $display("FAIL miss_handshake: got got=%b stable=%b dropped=%b want 111", got, st, dr); end
      n_vec++; if (slot_ok[0] !== 1'b1 || slot_dout[15:0] !== 16'hBEEF) begin
         n_err++; $display("FAIL miss_data: got ok=%b dout=%h want 1/beef", slot_ok[0], slot_dout[15:0]); end
   endtask

   task automatic test_hit_reuse();
      bit seen;
      slot_cs = 4'b0000; #1;
      n_vec++; if (slot_ok !== 4'b0) begin n_err++; $display("FAIL hit_cs_low: got %b want 0000", slot_ok); end
      @(negedge clk);
      slot_cs = 4'b0001; #1;
      n_vec++; if (slot_ok !== 4'b0001) begin n_err++; $display("FAIL hit_same_cycle: got %b want 0001", slot_ok); end
      seen = 1'b0;
      repeat (4) begin @(negedge clk); if (sdram_req !== 1'b0) seen = 1'b1; end
      n_vec++; if (seen) begin n_err++; $display("FAIL hit_no_req: got req=1 want 0"); end
   endtask

   task automatic test_round_robin();
      bit got, st, dr; logic [AW-1:0] ad; logic [DW-1:0] d;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 4; n++) a[n] = 22'(22'h100 * (r + 1) + n);
         slot_cs = 4'b1111;
         for (int k = 0; k < 4; k++) begin
            d = 16'($urandom);
            sdram_serve($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom), d, got, ad, st, dr);
            n_vec++; if (!got || ad !== a[k]) begin
               n_err++; $display("FAIL rr_order r%0d k%0d: got got=%b addr=%h want %h", r, k, got, ad, a[k]); end
            m_grant(k); m_fill(k, a[k], d);
            n_vec++; if (slot_ok !== m_ok() || slot_dout !== m_dvec()) begin
               n_err++; $display("FAIL rr_data r%0d k%0d: got ok=%b dout=%h want %b/%h", r, k, slot_ok, slot_dout, m_ok(), m_dvec()); end
         end
      end
   endtask

   task automatic test_addr_change();
      bit got, st, dr; logic [AW-1:0] ad;
      do_reset();
      a[2] = 22'h10; slot_cs = 4'b0100;
      wait_req(got);
      n_vec++; if (!got || sdram_addr !== 22'h10) begin n_err++; $display("FAIL chg_first_req: got got=%b addr=%h want 10", got, sdram_addr); end
      m_grant(2);
      sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
      a[2] = 22'h20; @(negedge clk);
      data_rdy = 1'b1; data_read = 16'h1111; @(negedge clk); data_rdy = 1'b0;
      m_fill(2, 22'h10, 16'h1111);
      n_vec++; if (slot_ok[2] !== 1'b0 || slot_dout[47:32] !== 16'h1111) begin
         n_err++; $display("FAIL chg_stale: got ok=%b dout=%h want 0/1111", slot_ok[2], slot_dout[47:32]); end
      @(negedge clk);
      n_vec++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h20) begin
         n_err++; $display("FAIL chg_rereq: got req=%b addr=%h want 1/20", sdram_req, sdram_addr); end
      sdram_serve(0, 1, 1'b0, 16'h2222, got, ad, st, dr);
      m_grant(2); m_fill(2, 22'h20, 16'h2222);
      n_vec++; if (slot_ok !== m_ok() || slot_dout !== m_dvec()) begin
         n_err++; $display("FAIL chg_final: got ok=%b dout=%h want %b/%h", slot_ok, slot_dout, m_ok(), m_dvec()); end
   endtask

   task automatic test_cs_drop();
      bit got, seen;
      a[1] = 22'h77; slot_cs = 4'b0010;
      wait_req(got);
      n_vec++; if (!got || sdram_addr !== 22'h77) begin n_err++; $display("FAIL drop_req: got got=%b addr=%h want 77", got, sdram_addr); end
      m_grant(1);
      slot_cs = 4'b0000;
      @(negedge clk); sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
      data_rdy = 1'b1; data_read = 16'h7777; @(negedge clk); data_rdy = 1'b0;
      m_fill(1, 22'h77, 16'h7777);
      slot_cs = 4'b0010; #1;
      n_vec++; if (slot_ok !== 4'b0010 || slot_dout !== m_dvec()) begin
         n_err++; $display("FAIL drop_cached: got ok=%b dout=%h want 0010/%h", slot_ok, slot_dout, m_dvec()); end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (sdram_req !== 1'b0) seen = 1'b1; end
      n_vec++; if (seen) begin n_err++; $display("FAIL drop_no_req: got req=1 want 0"); end
   endtask

   task automatic test_reset_mid_wait();
      bit got, st, dr; logic [AW-1:0] ad;
      do_reset();
      a[0] = 22'h3A5; slot_cs = 4'b0001;
      wait_req(got);
      sdram_ack = 1'b1; @(negedge clk); sdram_ack = 1'b0;
      rst = 1'b1; @(negedge clk);
      n_vec++; if (sdram_req !== 1'b0 || slot_ok !== 4'b0) begin
         n_err++; $display("FAIL rst_wait: got req=%b ok=%b want 0/0000", sdram_req, slot_ok); end
      slot_cs = 4'b0000; @(negedge clk); rst = 1'b0;
      data_rdy = 1'b1; data_read = 16'hABCD; @(negedge clk); data_rdy = 1'b0;
      slot_cs = 4'b0001; #1;
      n_vec++; if (slot_ok !== 4'b0 || slot_dout !== '0) begin
         n_err++; $display("FAIL rst_stray_rdy: got ok=%b dout=%h want 0000/0", slot_ok, slot_dout); end
      for (int n = 0; n < 4; n++) begin m_valid[n] = 1'b0; m_caddr[n] = '0; m_dout[n] = '0; end
      m_ptr = 3;
      sdram_serve(1, 0, 1'b1, 16'h5A5A, got, ad, st, dr);
      n_vec++; if (!got || ad !== 22'h3A5 || !st) begin
         n_err++; $display("FAIL rst_refetch: got got=%b addr=%h stable=%b want 1/3a5/1", got, ad, st); end
      m_grant(0); m_fill(0, 22'h3A5, 16'h5A5A);
   endtask

   task automatic test_prio();
      bit got, st, dr; logic [AW-1:0] ad; logic [AW-1:0] first, second;
      do_reset();
      a[0] = 22'h50; slot_cs = 4'b0001;
      sdram_serve(0, 0, 1'b0, 16'h0050, got, ad, st, dr);
      m_grant(0); m_fill(0, 22'h50, 16'h0050);
      a[0] = 22'h51; a[1] = 22'h61; slot_cs = 4'b0011;
`ifdef JTFRAME_ARB_PRIO0_EN
      first = 22'h51; second = 22'h61;
`else
      first = 22'h61; second = 22'h51;
`endif
      sdram_serve(0, 1, 1'b0, 16'h1001, got, ad, st, dr);
      n_vec++; if (!got || ad !== first) begin n_err++; $display("FAIL prio_first: got addr=%h want %h", ad, first); end
      m_grant(ad == 22'h51 ? 0 : 1); m_fill(ad == 22'h51 ? 0 : 1, ad, 16'h1001);
      sdram_serve(1, 0, 1'b0, 16'h1002, got, ad, st, dr);
      n_vec++; if (!got || ad !== second) begin n_err++; $display("FAIL prio_second: got addr=%h want %h", ad, second); end
      m_grant(ad == 22'h51 ? 0 : 1); m_fill(ad == 22'h51 ? 0 : 1, ad, 16'h1002);
   endtask

   task automatic test_random();
      bit got, st, dr, seen; logic [AW-1:0] ad; logic [AW-1:0] pool [4]; logic [DW-1:0] d; int s;
      for (int p = 0; p < 4; p++) pool[p] = 22'($urandom);
      for (int it = 0; it < 40; it++) begin
         for (int n = 0; n < 4; n++)
            if ($urandom_range(0, 2) == 0) a[n] = pool[$urandom_range(0, 3)];
         slot_cs = 4'($urandom_range(0, 15));
         #1;
         n_vec++; if (slot_ok !== m_ok()) begin n_err++; $display("FAIL rnd_ok it%0d: got %b want %b", it, slot_ok, m_ok()); end
         s = m_pick();
         if (s < 0) begin
            seen = 1'b0;
            repeat (2) begin @(negedge clk); if (sdram_req !== 1'b0) seen = 1'b1; end
            n_vec++; if (seen) begin n_err++; $display("FAIL rnd_idle it%0d: got req=1 want 0", it); end
         end else begin
            d = 16'($urandom);
            sdram_serve($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), d, got, ad, st, dr);
            n_vec++; if (!got || ad !== a[s] || !st || !dr) begin
               n_err++; $display("FAIL rnd_req it%0d: got got=%b addr=%h st=%b dr=%b want slot%0d addr=%h", it, got, ad, st, dr, s, a[s]); end
            m_grant(s); m_fill(s, a[s], d);
            n_vec++; if (slot_ok !== m_ok() || slot_dout !== m_dvec()) begin
               n_err++; $display("FAIL rnd_data it%0d: got ok=%b dout=%h want %b/%h", it, slot_ok, slot_dout, m_ok(), m_dvec()); end
         end
      end
   endtask

   task automatic test_stray();
      slot_cs = 4'b0000;
      @(negedge clk);
      sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 16'hDEAD;
      @(negedge clk);
      sdram_ack = 1'b0; data_rdy = 1'b0;
      @(negedge clk);
      n_vec++; if (sdram_req !== 1'b0 || slot_dout !== m_dvec()) begin
         n_err++; $display("FAIL stray_idle: got req=%b dout=%h want 0/%h", sdram_req, slot_dout, m_dvec()); end
   endtask

   initial begin
      rst = 1'b1; slot_cs = '0; sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
      for (int n = 0; n < 4; n++) a[n] = '0;
      test_reset();
      test_single_miss();
      test_hit_reuse();
      test_round_robin();
      test_addr_change();
      test_cs_drop();
      test_stray();
      test_reset_mid_wait();
      test_prio();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
